// File: rtl/tt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_pkg
// Description : Shared state encoding and default sizes for truth_table_sweeper
// Revision    : 1.0 - initial release
// ============================================================================
package tt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } tt_state_t;

  localparam int TT_N_IN_DEF   = 3;
  localparam int TT_SETTLE_DEF = 1;

endpackage
`default_nettype wire

// File: rtl/tt_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : tt_settle_timer
// Description : 4-bit loadable down-counter; expire flags the final settle cycle
// Revision    : 1.0 - initial release
// ============================================================================
module tt_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       expire
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign expire = en && (count == 4'd0);

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Sweeps all input vectors of a small cone, captures its truth
//               table and (with TT_CHECK_EN defined) checks it against a
//               reference table.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int N_IN   = TT_N_IN_DEF,
  parameter int SETTLE = TT_SETTLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [N_IN-1:0]      vec_out,
  input  logic                 fn_in,
  input  logic [2**N_IN-1:0]   expected,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 match,
  output logic [N_IN:0]        err_cnt
);

  localparam int            W    = 2**N_IN;
  localparam logic [N_IN:0] LAST = (N_IN+1)'(W - 1);

  tt_state_t      state;
  tt_state_t      state_nxt;
  logic [N_IN:0]  index;
  logic [N_IN:0]  index_inc;
  logic [W-1:0]   table_cap;
  logic           timer_load;
  logic           settle_expire;
  logic           accept;
  logic           last_sample;

  assign accept      = (state == ST_IDLE) && start;
  assign last_sample = (state == ST_SAMPLE) && (index == LAST);
  assign index_inc   = index + (N_IN+1)'(1);
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);

  generate
    if (SETTLE > 0) begin : g_timer
      localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);
      tt_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (SETTLE_LD),
        .en       (state == ST_SETTLE),
        .expire   (settle_expire)
      );
    end else begin : g_bypass
      logic unused_load;
      assign unused_load   = timer_load;
      assign settle_expire = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_DRIVE;
      end
      ST_DRIVE: begin
        timer_load = 1'b1;
        state_nxt  = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_expire) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        state_nxt = (index == LAST) ? ST_DONE : ST_DRIVE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Table with the bit currently being sampled folded in, so the compare
  // sees the final bit on the same edge that captures it.
  always_comb begin
    table_cap                    = table_out;
    table_cap[index[N_IN-1:0]]   = fn_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index     <= '0;
      vec_out   <= '0;
      table_out <= '0;
    end else if (accept) begin
      index     <= '0;
      vec_out   <= '0;
      table_out <= '0;
    end else if (state == ST_SAMPLE) begin
      table_out <= table_cap;
      if (index != LAST) begin
        index   <= index_inc;
        vec_out <= index_inc[N_IN-1:0];
      end
    end
  end

`ifdef TT_CHECK_EN
  logic [W-1:0]  diff;
  logic [N_IN:0] err_next;

  assign diff = table_cap ^ expected;

  always_comb begin
    err_next = '0;
    for (int i = 0; i < W; i++) begin
      err_next = err_next + {{N_IN{1'b0}}, diff[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match   <= 1'b0;
      err_cnt <= '0;
    end else if (accept) begin
      match   <= 1'b0;
      err_cnt <= '0;
    end else if (last_sample) begin
      err_cnt <= err_next;
      match   <= (err_next == '0);
    end
  end
`else
  logic unused_expected;
  logic unused_last;
  assign unused_expected = ^expected;
  assign unused_last     = last_sample;
  assign match           = 1'b0;
  assign err_cnt         = '0;
`endif

endmodule
`default_nettype wire

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Hardware stimulus-and-capture engine for small combinational cones. On `start` it drives every input vector 0..2^N_IN-1 in ascending binary order onto the cone and waits a programmable settle time. It samples the cone's single output bit and assembles the full truth table. It optionally compares the result against an expected table. It forms the observing end of the gate-level exercises: the cone under test is wired between `vec_out` and `fn_in`.

## Interface
- `N_IN`, 3: number of cone inputs; table width is `2**N_IN`.
- `SETTLE`, 1: settle cycles between driving a vector and sampling it; range 0..15.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request a sweep; sampled only in IDLE.
- `vec_out`  out  N_IN  vector driven to the cone; MSB is cone input A.
- `fn_in`  in  1  cone output, sampled in SAMPLE.
- `expected`  in  2**N_IN  reference table; bit i = expected f(i); must be stable from start to done.
- `busy`  out  1  high from the edge accepting `start` until the edge leaving DONE.
- `done`  out  1  one-cycle pulse; table and check results valid.
- `table_out`  out  2**N_IN  captured table; bit i = f(i); held until the next accepted start.
- `match`  out  1  table_out == expected; valid from done until the next accepted start.
- `err_cnt`  out  N_IN+1  count of differing bits.

## Operation
- Reset values: state IDLE, `vec_out`=0, `busy`=0, `done`=0, `table_out`=0, `match`=0, `err_cnt`=0, index=0.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE + `start`=1: go to DRIVE. Set `busy`=1, index=0, `vec_out`=0, and clear `table_out`, `match` and `err_cnt`.
- DRIVE lasts 1 cycle, then goes to SETTLE. If SETTLE=0, it goes directly to SAMPLE.
- SETTLE lasts exactly SETTLE cycles, timed by a down-counter, then goes to SAMPLE.
- SAMPLE lasts 1 cycle. On the exiting edge, `table_out[index]` <= `fn_in`.
  - If index == 2**N_IN-1, go to DONE.
  - Otherwise increment index, set `vec_out` = index+1, and go to DRIVE.
- DONE lasts 1 cycle with `done`=1, then goes to IDLE with `busy`=0.
- `start` while `busy`=1 is ignored; no queuing.
- `start` held high through DONE starts a new sweep from the IDLE cycle that follows.
- Async reset mid-sweep aborts immediately; all outputs take their reset values.
- Index width is N_IN+1 internally, so the terminal compare never wraps. `vec_out` is the low N_IN bits.

## Timing
- Accepting edge k: new `vec_out` is visible after each edge entering DRIVE.
- `fn_in` for vector i is sampled SETTLE+1 cycles after `vec_out`=i is driven.
- Per-vector cost is SETTLE+2 cycles.
- `done` is high in the cycle after edge k + 2**N_IN·(SETTLE+2). Defaults: k+24.
- `match` and `err_cnt` are registered on the DONE-entering edge, coincident with `done`.
- Minimum start-to-start interval: 2**N_IN·(SETTLE+2)+2 cycles.

## Configuration
- `TT_CHECK_EN` defined: compare logic is present.
  - On the DONE-entering edge, `err_cnt` = popcount(`table_out` ^ `expected`), computed with the final bit included.
  - `match` = (`err_cnt`==0).
- `TT_CHECK_EN` undefined: `expected` is unused, and `match` and `err_cnt` are constant 0.
- Capture and FSM timing are identical in both cases.

## Structure
- Package `tt_pkg` holds:
  - the state enum `tt_state_t` (IDLE, DRIVE, SETTLE, SAMPLE, DONE);
  - the default constants `TT_N_IN_DEF`=3 and `TT_SETTLE_DEF`=1.
- One sub-module, `tt_settle_timer`: a 4-bit loadable down-counter.
  - Load pulse from DRIVE; `expire` asserts on its final count.
  - For SETTLE=0 it is bypassed.
- FSM, index, capture and compare stay in the top module.

## Test plan
- Wire the cone f = (!A&(B|C)) | !(A|B), with {A,B,C}=`vec_out`. Set `expected`=8'h0F and pulse `start`.
  - Expect `table_out`=8'h0F, `match`=1, `err_cnt`=0.
  - `done` pulses exactly 24 cycles after the accepting edge.
- Same cone, `expected`=8'h1E: expect `match`=0 and `err_cnt`=2 (with TT_CHECK_EN). Without TT_CHECK_EN: `match`=0, `err_cnt`=0, `table_out`=8'h0F.
- `fn_in` tied 1, SETTLE=0: expect `table_out`=8'hFF and `done` at 16 cycles. `vec_out` steps 0..7, each held 2 cycles.
- Pulse `start` again at cycle 10 of a sweep: expect it ignored, a single `done`, and unchanged timing.
- Assert `rst_n`=0 mid-sweep at vector 5: outputs go to reset values immediately with no `done`. A fresh `start` afterwards completes normally.
- `start` held high continuously: expect back-to-back sweeps, `done` every 26 cycles, and `table_out` cleared at each restart.
